// File: rtl/cp0_regfile_pkg.sv
// Purpose: shared CP0 register indices, field positions and exception codes.
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.
package cp0_defs;

    // Register indices as seen on the mfc0/mtc0 address fields
    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    // SR field positions
    localparam int IM_HI = 15;
    localparam int IM_LO = 10;
    localparam int EXL   = 1;
    localparam int IE    = 0;

    // Cause field positions
    localparam int BD     = 31;
    localparam int IP_HI  = 15;
    localparam int IP_LO  = 10;
    localparam int EXC_HI = 6;
    localparam int EXC_LO = 2;

    // ExcCode values shared with the exception-detect logic
    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    // Word-align an address by clearing its low two bits
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/cp0_regfile_if.sv
// Purpose: bundles the CP0 read/write, exception and status signals.
// Latency: n/a (wiring only).
// Backpressure: none; all signals are single-cycle level signals.
interface cp0_regfile_if;

    logic [4:0]  A1;
    logic [4:0]  A2;
    logic [31:0] DIn;
    logic        We;
    logic [31:0] PC;
    logic        BD;
    logic        Exception;
    logic [4:0]  Exc;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic [31:0] DOut;
    logic [31:0] EPC;
    logic        exl;
    logic        ie;
    logic [5:0]  im;

    // Pipeline side: drives requests, observes status
    modport master (
        output A1, A2, DIn, We, PC, BD, Exception, Exc, HWInt, EXLClr,
        input  DOut, EPC, exl, ie, im
    );

    // Register file side
    modport slave (
        input  A1, A2, DIn, We, PC, BD, Exception, Exc, HWInt, EXLClr,
        output DOut, EPC, exl, ie, im
    );

endinterface

// File: rtl/cp0_regfile.sv
// Purpose: CP0 SR/Cause/EPC/PRId storage with mfc0/mtc0/eret and exception capture.
// Latency: reads combinational; writes, captures and IP sampling visible one edge later.
// Backpressure: none; stalls/forwarding are handled by the surrounding pipeline.
module cp0_regfile
    import cp0_defs::*;
#(
    parameter logic [31:0] PRID     = 32'h0000_2017,
    parameter logic [31:0] SR_RESET = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    cp0_regfile_if.slave bus
);

    logic [5:0]  sr_im;
    logic        sr_exl;
    logic        sr_ie;
    logic        cause_bd;
    logic [5:0]  cause_ip;
    logic [4:0]  cause_exc;
    logic [31:0] epc_q;
    logic [31:0] dout;

    logic wr_sr;
    logic wr_epc;
    logic [31:0] victim_pc;
    logic        unused_bits;

    // mtc0 only lands when no exception claims the same edge
    assign wr_sr     = bus.We && !bus.Exception && (bus.A2 == CP0_SR);
    assign wr_epc    = bus.We && !bus.Exception && (bus.A2 == CP0_EPC);

    // A delay-slot victim restarts at the branch, one word earlier
    assign victim_pc = bus.BD ? (word_align(bus.PC) - 32'd4) : word_align(bus.PC);

    assign unused_bits = ^bus.PC[1:0];

    // SR: exception sets EXL; eret clears EXL but still lets a same-edge mtc0 set IM/IE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_im  <= SR_RESET[IM_HI:IM_LO];
            sr_exl <= SR_RESET[EXL];
            sr_ie  <= SR_RESET[IE];
        end else if (bus.Exception) begin
            sr_exl <= 1'b1;
        end else begin
            if (wr_sr) begin
                sr_im <= bus.DIn[IM_HI:IM_LO];
                sr_ie <= bus.DIn[IE];
            end
            if (bus.EXLClr) begin
                sr_exl <= 1'b0;
            end else if (wr_sr) begin
                sr_exl <= bus.DIn[EXL];
            end
        end
    end

    // Cause: IP tracks HWInt every edge; BD/ExcCode only change on exception capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cause_bd  <= 1'b0;
            cause_ip  <= '0;
            cause_exc <= '0;
        end else begin
            cause_ip <= bus.HWInt;
            if (bus.Exception) begin
                cause_bd  <= bus.BD;
                cause_exc <= bus.Exc;
            end
        end
    end

    // EPC: exception capture wins over an mtc0 write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            epc_q <= '0;
        end else if (bus.Exception) begin
            epc_q <= victim_pc;
        end else if (wr_epc) begin
            epc_q <= word_align(bus.DIn);
        end
    end

    // mfc0 read mux from current register contents, no write bypass
    always_comb begin
        dout = '0;
        case (bus.A1)
            CP0_SR: begin
                dout[IM_HI:IM_LO] = sr_im;
                dout[EXL]         = sr_exl;
                dout[IE]          = sr_ie;
            end
            CP0_CAUSE: begin
                dout[BD]            = cause_bd;
                dout[IP_HI:IP_LO]   = cause_ip;
                dout[EXC_HI:EXC_LO] = cause_exc;
            end
            CP0_EPC:  dout = epc_q;
            CP0_PRID: dout = PRID;
            default:  dout = '0;
        endcase
    end

    assign bus.DOut = dout;
    assign bus.EPC  = epc_q;
    assign bus.exl  = sr_exl;
    assign bus.ie   = sr_ie;
    assign bus.im   = sr_im;

endmodule

// File: tb/tb_cp0_regfile.sv
// Purpose: self-checking bench for cp0_regfile against a word-level register model.
// Latency: checks outputs 2ns after each rising edge, model advanced on the edge.
// Backpressure: n/a.
module tb_cp0_regfile;

    localparam logic [31:0] PRID_V  = 32'h0000_2017;
    localparam logic [31:0] SR_MASK = 32'h0000_FC03;

    logic clk;
    logic reset;

    cp0_regfile_if bus();

    cp0_regfile #(.PRID(PRID_V), .SR_RESET(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference state as whole architectural words
    logic [31:0] m_sr;
    logic [31:0] m_cause;
    logic [31:0] m_epc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [31:0] m_read(input logic [4:0] idx);
        case (idx)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return PRID_V;
            default: return 32'h0;
        endcase
    endfunction

    task automatic m_reset();
        m_sr    = 32'h0;
        m_cause = 32'h0;
        m_epc   = 32'h0;
    endtask

    // Apply one clock edge worth of architectural rules to the model
    task automatic m_edge();
        logic [31:0] nsr, ncause, nepc, pcw;
        nsr    = m_sr;
        nepc   = m_epc;
        ncause = (m_cause & ~32'h0000_FC00) | (32'(bus.HWInt) << 10);
        if (bus.Exception) begin
            nsr    = m_sr | 32'h2;
            ncause = (32'(bus.BD) << 31) | (32'(bus.HWInt) << 10) | (32'(bus.Exc) << 2);
            pcw    = bus.PC & ~32'h3;
            nepc   = bus.BD ? pcw - 32'd4 : pcw;
        end else begin
            if (bus.We && bus.A2 == 5'd12) nsr = bus.DIn & SR_MASK;
            if (bus.EXLClr)                nsr = nsr & ~32'h2;
            if (bus.We && bus.A2 == 5'd14) nepc = bus.DIn & ~32'h3;
        end
        m_sr    = nsr;
        m_cause = ncause;
        m_epc   = nepc;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".dout"}, bus.DOut, m_read(bus.A1));
        chk({tag, ".epc"},  bus.EPC, m_epc);
        chk({tag, ".exl"},  32'(bus.exl), 32'(m_sr[1]));
        chk({tag, ".ie"},   32'(bus.ie), 32'(m_sr[0]));
        chk({tag, ".im"},   32'(bus.im), 32'(m_sr[15:10]));
    endtask

    task automatic drive(input logic [4:0] a1, input logic [4:0] a2, input logic [31:0] din,
                         input logic we, input logic [31:0] pc, input logic bd,
                         input logic exc_v, input logic [4:0] exc, input logic [5:0] hw,
                         input logic eret);
        bus.A1 = a1; bus.A2 = a2; bus.DIn = din; bus.We = we;
        bus.PC = pc; bus.BD = bd; bus.Exception = exc_v; bus.Exc = exc;
        bus.HWInt = hw; bus.EXLClr = eret;
    endtask

    // One edge: advance model with the held inputs, then compare
    task automatic step(input string tag);
        @(posedge clk);
        m_edge();
        #2;
        check_all(tag);
    endtask

    initial begin
        reset = 1'b1;
        drive(5'd12, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 6'd0, 1'b0);
        m_reset();
        #11;
        check_all("reset");
        chk("reset.sr_const", bus.DOut, 32'h0);
        reset = 1'b0;

        // mtc0 SR, then read it back
        drive(5'd12, 5'd12, 32'h0000_0C01, 1'b1, 32'h0, 1'b0, 1'b0, 5'd0, 6'd0, 1'b0);
        step("mtc0_sr");
        chk("mtc0_sr.im_const", 32'(bus.im), 32'h3);
        chk("mtc0_sr.ie_const", 32'(bus.ie), 32'h1);
        chk("mtc0_sr.exl_const", 32'(bus.exl), 32'h0);
        chk("mtc0_sr.read_const", bus.DOut, 32'h0000_0C01);

        // Plain exception, ADEL
        drive(5'd13, 5'd0, 32'h0, 1'b0, 32'h0000_3008, 1'b0, 1'b1, 5'd4, 6'd0, 1'b0);
        step("exc_adel");
        chk("exc_adel.epc_const", bus.EPC, 32'h3008);
        chk("exc_adel.exl_const", 32'(bus.exl), 32'h1);
        chk("exc_adel.cause_const", bus.DOut, 32'h0000_0010);

        // Delay-slot exception with an interrupt line held
        drive(5'd13, 5'd0, 32'h0, 1'b0, 32'h0000_3014, 1'b1, 1'b1, 5'd0, 6'b000001, 1'b0);
        step("exc_bd");
        chk("exc_bd.epc_const", bus.EPC, 32'h3010);
        chk("exc_bd.cause_const", bus.DOut, 32'h8000_0400);

        // Exception beats a same-edge mtc0 to EPC
        drive(5'd14, 5'd14, 32'hDEAD_BEEF, 1'b1, 32'h0000_3000, 1'b0, 1'b1, 5'd12, 6'd0, 1'b0);
        step("exc_vs_mtc0");
        chk("exc_vs_mtc0.epc_const", bus.EPC, 32'h3000);
        drive(5'd14, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 6'd0, 1'b1);
        step("eret");
        chk("eret.exl_const", 32'(bus.exl), 32'h0);
        chk("eret.epc_const", bus.EPC, 32'h3000);

        // Unmapped index, PRId, and write to read-only PRId
        drive(5'd7, 5'd7, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b0, 1'b0, 5'd0, 6'd0, 1'b0);
        step("unmapped");
        chk("unmapped.read_const", bus.DOut, 32'h0);
        drive(5'd15, 5'd15, 32'h1234_5678, 1'b1, 32'h0, 1'b0, 1'b0, 5'd0, 6'd0, 1'b0);
        step("prid_wr");
        chk("prid_wr.read_const", bus.DOut, PRID_V);

        // eret plus mtc0 SR on the same edge: EXL cleared, IM/IE from DIn
        drive(5'd12, 5'd12, 32'h0000_FC03, 1'b1, 32'h0, 1'b0, 1'b0, 5'd0, 6'd0, 1'b1);
        step("eret_mtc0_sr");
        chk("eret_mtc0_sr.read_const", bus.DOut, 32'h0000_FC01);

        // Randomised traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [4:0] a1, a2;
            a1 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 3));
            a2 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'(12 + $urandom_range(0, 3));
            drive(a1, a2, $urandom, 1'($urandom_range(0, 1)), $urandom,
                  1'($urandom_range(0, 1)), ($urandom_range(0, 7) == 0),
                  5'($urandom), 6'($urandom), ($urandom_range(0, 5) == 0));
            step("rand");
        end

        // Load EPC, then assert reset between edges
        drive(5'd14, 5'd14, 32'h0000_3010, 1'b1, 32'h0, 1'b0, 1'b0, 5'd0, 6'd0, 1'b0);
        step("pre_reset");
        chk("pre_reset.epc_const", bus.EPC, 32'h3010);
        drive(5'd12, 5'd0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 5'd0, 6'd0, 1'b0);
        #2;
        reset = 1'b1;
        m_reset();
        #1;
        check_all("async_reset");
        chk("async_reset.epc_const", bus.EPC, 32'h0);
        #1;
        reset = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
- Coprocessor-0 register file. It consumes the `Exception`/`Exc` result from the exception-detect logic in the M stage.
- It returns the interrupt/exception gating state that this logic needs: `exl`, `ie`, `im`.
- It holds SR, Cause, EPC and PRId, and services `mfc0`/`mtc0`/`eret`.
- It sits beside the M-stage pipeline register, and `EPC` feeds the PC-select mux.

Parameters:
- `PRID`, default 32'h0000_2017, read-only processor ID value returned for register 15.
- `SR_RESET`, default 32'h0000_0000, reset image of SR (only IM/EXL/IE bits honoured).

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  asynchronous, active-high; clears/initialises all state
- `A1`  in  5  mfc0 read register index
- `A2`  in  5  mtc0 write register index
- `DIn`  in  32  mtc0 write data
- `We`  in  1  mtc0 write enable
- `PC`  in  32  M-stage instruction PC (victim PC)
- `BD`  in  1  M-stage instruction is in a branch delay slot
- `Exception`  in  1  exception/interrupt accepted this cycle (already masked by `exl`)
- `Exc`  in  5  exception code accompanying `Exception`
- `HWInt`  in  6  external hardware interrupt lines
- `EXLClr`  in  1  eret in M stage
- `DOut`  out  32  mfc0 read data
- `EPC`  out  32  current EPC register
- `exl`  out  1  SR.EXL
- `ie`  out  1  SR.IE
- `im`  out  6  SR.IM[15:10]

Behaviour:
- Register map (index on `A1`/`A2`): 12=SR, 13=Cause, 14=EPC, 15=PRId. Any other index reads 32'h0, and writes to it are ignored.
- SR layout: IM = bits [15:10], EXL = bit [1], IE = bit [0]. All other SR bits read 0.
- Cause layout: BD = bit [31], IP = bits [15:10], ExcCode = bits [6:2]. All other Cause bits read 0.
- Reset (async, active-high):
  - IM/EXL/IE take their values from `SR_RESET`.
  - Cause = 0, EPC = 0.
  - Outputs follow immediately: `DOut` shows the reset image for the selected index, `EPC` = 0, `exl`/`ie`/`im` per `SR_RESET`.
- IP sampling: every clock edge, Cause.IP <= `HWInt`, regardless of all other inputs. There is one cycle of latency from `HWInt` to a readable IP.
- Exception capture (`Exception`=1 on an edge), all in one edge:
  - EXL <= 1.
  - Cause.ExcCode <= `Exc`.
  - Cause.BD <= `BD`.
  - EPC <= `BD` ? {`PC`[31:2],2'b00} - 4 : {`PC`[31:2],2'b00}.
- eret (`EXLClr`=1, `Exception`=0): EXL <= 0. EPC, Cause and IM/IE are unchanged.
- mtc0 (`We`=1, `Exception`=0):
  - SR: IM/EXL/IE <= the corresponding `DIn` bits.
  - EPC <= {`DIn`[31:2],2'b00}.
  - Cause and PRId are read-only; writes to them are ignored.
- Priority on the same edge: `Exception` > `EXLClr` > `We`.
  - An exception suppresses both a same-cycle mtc0 and a same-cycle eret.
  - eret and an mtc0 to SR on the same edge: EXL <= 0, and IM/IE still take `DIn`.
  - mtc0 to EPC on the same edge as eret: the EPC write happens.
- Read path: `DOut` is combinational from the current register contents. A same-cycle mtc0 to the same index returns the old value; there is no internal bypass. The pipeline stalls or forwards externally.
- `EPC` output is the register value; the same-cycle captured value is not bypassed.
- `exl`/`ie`/`im` are direct register outputs, so an exception sets `exl` visibly in the cycle after capture. This blocks back-to-back re-entry.
- `Exception` is assumed gated by `~exl` upstream. If it arrives with EXL=1 it is still honoured, and EPC is overwritten.

Decomposition:
- Shared package `cp0_defs` holds:
  - register indices `CP0_SR`=12, `CP0_CAUSE`=13, `CP0_EPC`=14, `CP0_PRID`=15;
  - field bit positions (IM_HI/IM_LO, EXL, IE, BD, IP_HI/IP_LO, EXC_HI/EXC_LO);
  - ExcCode constants `EXC_INT`=0, `EXC_ADEL`=4, `EXC_ADES`=5, `EXC_RI`=10, `EXC_OV`=12.
- The exception-detect logic imports the same constants.
- No sub-module; a single flat module.

Test Plan:
- Reset asserted mid-cycle with EPC=32'h3010 -> `EPC`=0, `exl`=0, `ie`=0, `im`=0 immediately, without waiting for a clock edge.
- mtc0 `A2`=12, `DIn`=32'h0000_0C01 -> next cycle `im`=6'b000011, `ie`=1, `exl`=0. `A1`=12 reads 32'h0000_0C01.
- `Exception`=1, `Exc`=5'd4, `PC`=32'h0000_3008, `BD`=0 -> `EPC`=32'h3008, `exl`=1. Cause reads 32'h0000_0010 (IP=0).
- `Exception`=1, `BD`=1, `PC`=32'h0000_3014, `Exc`=0, `HWInt`=6'b000001 held -> `EPC`=32'h3010, Cause=32'h8000_0400.
- `Exception` and `We` (`A2`=14, `DIn`=32'hDEAD_BEEF) on the same edge with `PC`=32'h3000 -> `EPC`=32'h3000, and the write is dropped. A following `EXLClr` -> `exl`=0 and `EPC` unchanged.
- `A1`=7 -> `DOut`=0. `A1`=15 -> `DOut`=`PRID`. mtc0 to 15 -> PRId unchanged.
